// File: rtl/ctrl_pkg.sv
// Shared types for the RV32I decode stage: opcodes, ALU/immediate/result
// encodings and the control bundle held in the ID/EX register.
package ctrl_pkg;

    localparam int ALU_W = 4;
    localparam int REG_W = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU, RES_MEM, RES_PC4, RES_IMM
    } result_src_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jump2;
        logic        alu_src;
        result_src_e result_src;
        imm_src_e    imm_src;
        alu_op_e     alu_ctrl;
        logic [2:0]  funct3;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic        illegal;
    } ctrl_bundle_t;

    // alt is instr[30]; it only means SUB for register-register ops, since
    // for OP-IMM with funct3=000 that bit belongs to the immediate.
    function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt,
                                        input logic reg_op);
        case (f3)
            3'b000:  return (alt && reg_op) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational RV32I control decoder: instruction word to control bundle,
// plus which source registers the instruction actually reads.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t ctrl,
    output logic         rs1_used,
    output logic         rs2_used
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       alt;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign f3          = instr[14:12];
    assign alt         = instr[30];
    assign unused_bits = ^{instr[31], instr[29:25]};

    always_comb begin
        ctrl        = '0;
        ctrl.funct3 = f3;
        ctrl.rs1    = instr[19:15];
        ctrl.rs2    = instr[24:20];
        ctrl.rd     = instr[11:7];
        rs1_used    = 1'b1;
        rs2_used    = 1'b0;

        case (opcode)
            OPC_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_ctrl   = ALU_ADD;
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_S;
                ctrl.alu_ctrl  = ALU_ADD;
                rs2_used       = 1'b1;
            end
            OPC_OPIMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_I;
                ctrl.alu_ctrl  = alu_sel(f3, alt, 1'b0);
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_sel(f3, alt, 1'b1);
                rs2_used       = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.imm_src  = IMM_B;
                ctrl.alu_ctrl = ALU_SUB;
                rs2_used      = 1'b1;
            end
            OPC_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.imm_src    = IMM_J;
                rs1_used        = 1'b0;
            end
            OPC_JALR: begin
                // JALR is only defined with funct3=000; anything else is reserved
                if (f3 == 3'b000) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.jump2      = 1'b1;
                    ctrl.alu_src    = 1'b1;
                    ctrl.result_src = RES_PC4;
                    ctrl.imm_src    = IMM_I;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_IMM;
                ctrl.imm_src    = IMM_U;
                rs1_used        = 1'b0;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered RV32I decode stage (ID/EX register) with valid/ready handshake,
// load-use bubble and flush. Optional counters: CTRL_DECODE_PERF_CNT_EN.
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int PERF_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     instr,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      RegWrite,
    output logic                      MemWrite,
    output logic                      Branch,
    output logic                      Jump,
    output logic                      Jump2,
    output logic                      ALUsrc,
    output logic [1:0]                ResultSrc,
    output logic [2:0]                ImmSrc,
    output logic [ALU_CTRL_WIDTH-1:0] ALUctrl,
    output logic [2:0]                funct3,
    output logic [REG_ADDR_WIDTH-1:0] rs1,
    output logic [REG_ADDR_WIDTH-1:0] rs2,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic                      illegal,
`ifdef CTRL_DECODE_PERF_CNT_EN
    output logic [PERF_CNT_WIDTH-1:0] perf_issued,
    output logic [PERF_CNT_WIDTH-1:0] perf_bubbles,
    output logic [PERF_CNT_WIDTH-1:0] perf_flushes,
`endif
    output logic                      load_use_stall
);

    ctrl_bundle_t dec;
    ctrl_bundle_t q;
    logic         vld_q;
    logic         rs1_used;
    logic         rs2_used;
    logic         hazard;
    logic         accept;

    ctrl_decoder u_dec (
        .instr    (instr[31:0]),
        .ctrl     (dec),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    // Held load writes a register the incoming instruction reads.
    assign hazard = vld_q && (q.result_src == RES_MEM) && (q.rd != '0) && in_valid &&
                    ((rs1_used && (dec.rs1 == q.rd)) || (rs2_used && (dec.rs2 == q.rd)));

    assign load_use_stall = hazard && !flush;
    assign in_ready       = flush || ((!vld_q || out_ready) && !hazard);
    // in_ready without flush already excludes the hazard case
    assign accept         = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (hazard && out_ready) begin
            vld_q <= 1'b0;
        end else if (accept) begin
            vld_q <= 1'b1;
        end else if (out_ready) begin
            vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (accept) begin
            q <= dec;
        end
    end

    assign out_valid = vld_q;
    assign RegWrite  = q.reg_write;
    assign MemWrite  = q.mem_write;
    assign Branch    = q.branch;
    assign Jump      = q.jump;
    assign Jump2     = q.jump2;
    assign ALUsrc    = q.alu_src;
    assign ResultSrc = q.result_src;
    assign ImmSrc    = q.imm_src;
    assign ALUctrl   = ALU_CTRL_WIDTH'(q.alu_ctrl);
    assign funct3    = q.funct3;
    assign rs1       = REG_ADDR_WIDTH'(q.rs1);
    assign rs2       = REG_ADDR_WIDTH'(q.rs2);
    assign rd        = REG_ADDR_WIDTH'(q.rd);
    assign illegal   = q.illegal;

`ifdef CTRL_DECODE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued  <= '0;
            perf_bubbles <= '0;
            perf_flushes <= '0;
        end else begin
            if (accept)
                perf_issued <= perf_issued + PERF_CNT_WIDTH'(1);
            if (load_use_stall && out_ready)
                perf_bubbles <= perf_bubbles + PERF_CNT_WIDTH'(1);
            if (flush && (vld_q || in_valid))
                perf_flushes <= perf_flushes + PERF_CNT_WIDTH'(1);
        end
    end
`else
    localparam int unused_perf_w = PERF_CNT_WIDTH;
`endif

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: directed scenarios plus random traffic checked
// every cycle against a rule-level model of the stage.
module tb_ctrl_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr;
    logic        RegWrite, MemWrite, Branch, Jump, Jump2, ALUsrc, illegal, load_use_stall;
    logic [1:0]  ResultSrc;
    logic [2:0]  ImmSrc, funct3;
    logic [3:0]  ALUctrl;
    logic [4:0]  rs1, rs2, rd;
`ifdef CTRL_DECODE_PERF_CNT_EN
    logic [31:0] perf_issued, perf_bubbles, perf_flushes;
`endif

    always #5 clk = ~clk;

    ctrl_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
        .Jump2(Jump2), .ALUsrc(ALUsrc), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .ALUctrl(ALUctrl), .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd(rd),
        .illegal(illegal),
`ifdef CTRL_DECODE_PERF_CNT_EN
        .perf_issued(perf_issued), .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes),
`endif
        .load_use_stall(load_use_stall)
    );

    int nchk  = 0;
    int npass = 0;
    logic run_cmp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic rw, mw, br, j, j2, asrc;
        logic [1:0] res;
        logic [2:0] imm;
        logic [3:0] alu;
        logic [2:0] f3;
        logic [4:0] r1, r2, rd;
        logic ill, u1, u2;
    } exp_t;

    function automatic exp_t model_dec(input logic [31:0] i);
        exp_t e = '0;
        int   tbl[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
        logic [6:0] op = i[6:0];
        logic ld = (op == 7'h03), st = (op == 7'h23), oi = (op == 7'h13);
        logic rr = (op == 7'h33), bq = (op == 7'h63), jl = (op == 7'h6F);
        logic jr = (op == 7'h67) && (i[14:12] == 3'd0), lu = (op == 7'h37);
        e.ill  = !(ld || st || oi || rr || bq || jl || jr || lu);
        e.rw   = ld || oi || rr || jl || jr || lu;
        e.mw   = st;
        e.br   = bq;
        e.j    = jl;
        e.j2   = jr;
        e.asrc = ld || st || oi || jr;
        e.res  = ld ? 2'd1 : (jl || jr) ? 2'd2 : lu ? 2'd3 : 2'd0;
        e.imm  = st ? 3'd1 : bq ? 3'd2 : jl ? 3'd3 : lu ? 3'd4 : 3'd0;
        if (oi || rr) begin
            e.alu = 4'(tbl[i[14:12]]);
            if (i[30] && i[14:12] == 3'd5) e.alu = 4'd9;
            if (rr && i[30] && i[14:12] == 3'd0) e.alu = 4'd1;
        end
        if (bq) e.alu = 4'd1;
        e.f3 = i[14:12];
        e.r1 = i[19:15];
        e.r2 = i[24:20];
        e.rd = i[11:7];
        e.u1 = !(jl || lu);
        e.u2 = rr || st || bq;
        return e;
    endfunction

    logic  mvalid;
    exp_t  mb, md;
    logic  e_haz, e_stall, e_iry;
    logic [31:0] mi, mbub, mfl;

    always_comb begin
        md      = model_dec(instr);
        e_haz   = mvalid && (mb.res == 2'd1) && (mb.rd != 5'd0) && in_valid &&
                  ((md.u1 && md.r1 == mb.rd) || (md.u2 && md.r2 == mb.rd));
        e_stall = e_haz && !flush;
        e_iry   = flush || ((!mvalid || out_ready) && !e_haz);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mvalid <= 1'b0; mb <= '0; mi <= 0; mbub <= 0; mfl <= 0;
        end else begin
            if (flush) mvalid <= 1'b0;
            else if (e_haz && out_ready) mvalid <= 1'b0;
            else if (in_valid && e_iry) begin mvalid <= 1'b1; mb <= md; end
            else if (out_ready) mvalid <= 1'b0;
            if (in_valid && e_iry && !flush) mi <= mi + 1;
            if (e_stall && out_ready) mbub <= mbub + 1;
            if (flush && (mvalid || in_valid)) mfl <= mfl + 1;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("out_valid", 32'(out_valid), 32'(mvalid));
            chk("in_ready", 32'(in_ready), 32'(e_iry));
            chk("load_use_stall", 32'(load_use_stall), 32'(e_stall));
            if (mvalid) begin
                chk("RegWrite", 32'(RegWrite), 32'(mb.rw));
                chk("MemWrite", 32'(MemWrite), 32'(mb.mw));
                chk("Branch", 32'(Branch), 32'(mb.br));
                chk("Jump", 32'(Jump), 32'(mb.j));
                chk("Jump2", 32'(Jump2), 32'(mb.j2));
                chk("ALUsrc", 32'(ALUsrc), 32'(mb.asrc));
                chk("ResultSrc", 32'(ResultSrc), 32'(mb.res));
                chk("ImmSrc", 32'(ImmSrc), 32'(mb.imm));
                chk("ALUctrl", 32'(ALUctrl), 32'(mb.alu));
                chk("funct3", 32'(funct3), 32'(mb.f3));
                chk("rs1", 32'(rs1), 32'(mb.r1));
                chk("rs2", 32'(rs2), 32'(mb.r2));
                chk("rd", 32'(rd), 32'(mb.rd));
                chk("illegal", 32'(illegal), 32'(mb.ill));
            end
`ifdef CTRL_DECODE_PERF_CNT_EN
            chk("perf_issued", perf_issued, mi);
            chk("perf_bubbles", perf_bubbles, mbub);
            chk("perf_flushes", perf_flushes, mfl);
`endif
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [31:0] SUB   = 32'h40B50533;  // sub  a0,a0,a1
    localparam logic [31:0] LUI   = 32'h000500B7;  // lui  ra,0x50
    localparam logic [31:0] LW5   = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] ADD6  = 32'h00228333;  // add  x6,x5,x2
    localparam logic [31:0] LW0   = 32'h0000A003;  // lw   x0,0(x1)
    localparam logic [31:0] ADD60 = 32'h00200333;  // add  x6,x0,x2
    localparam logic [31:0] ADDI  = 32'h00100093;  // addi x1,x0,1
    localparam logic [31:0] XOR3  = 32'h0020C1B3;  // xor  x3,x1,x2
    localparam logic [31:0] BEQ   = 32'h00208063;  // beq  x1,x2,0

    task automatic drv(input logic v, input logic [31:0] ins, input logic f, input logic r);
        in_valid = v; instr = ins; flush = f; out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] w = $urandom;
        logic [6:0]  ops[10] = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h63,
                                 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
        if ($urandom_range(0, 15) == 0) return w;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        if (w[6:0] == 7'h67 && $urandom_range(0, 3) != 0) w[14:12] = 3'd0;
        return w;
    endfunction

    initial begin
        exp_t pin;
        rst_n = 1'b0;
        drv(0, 32'h0, 0, 0);

        // model sanity against hand-decoded words
        pin = model_dec(SUB);
        chk("model_sub_alu", 32'(pin.alu), 32'd1);
        pin = model_dec(LUI);
        chk("model_lui_imm", 32'(pin.imm), 32'd4);
        pin = model_dec(LW5);
        chk("model_lw_res", 32'(pin.res), 32'd1);
        pin = model_dec(32'hFFFFFFFF);
        chk("model_ill", 32'(pin.ill), 32'd1);

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_alu", 32'(ALUctrl), 32'd0);
        step();
        rst_n   = 1'b1;
        run_cmp = 1'b1;

        // decode sweep and load-use
        drv(1, SUB, 0, 1); step();
        drv(1, LUI, 0, 1); #1;
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_regwrite", 32'(RegWrite), 32'd1);
        chk("sub_alu", 32'(ALUctrl), 32'd1);
        chk("sub_imm", 32'(ImmSrc), 32'd0);
        chk("sub_alusrc", 32'(ALUsrc), 32'd0);
        chk("sub_rd", 32'(rd), 32'd10);
        step();
        drv(1, LW5, 0, 1); #1;
        chk("lui_res", 32'(ResultSrc), 32'd3);
        chk("lui_imm", 32'(ImmSrc), 32'd4);
        step();
        drv(1, ADD6, 0, 1); #1;
        chk("lu_stall", 32'(load_use_stall), 32'd1);
        chk("lu_in_ready", 32'(in_ready), 32'd0);
        step(); #1;
        chk("lu_bubble", 32'(out_valid), 32'd0);
        chk("lu_stall_gone", 32'(load_use_stall), 32'd0);
        chk("lu_ready_again", 32'(in_ready), 32'd1);
        step();
        drv(1, LW0, 0, 1); #1;
        chk("add_issued", 32'(out_valid), 32'd1);
        chk("add_rd", 32'(rd), 32'd6);
        step();
        drv(1, ADD60, 0, 1); #1;
        chk("x0_no_stall", 32'(load_use_stall), 32'd0);
        chk("x0_ready", 32'(in_ready), 32'd1);
        step();

        // back-pressure
        drv(1, ADDI, 0, 1); step();
        drv(1, XOR3, 0, 0);
        repeat (3) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_rd_stable", 32'(rd), 32'd1);
            step();
        end
        drv(1, XOR3, 0, 1); #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step(); #1;
        chk("bp_next_rd", 32'(rd), 32'd3);

        // flush while holding a branch
        drv(1, BEQ, 0, 1); step();
        drv(1, ADDI, 1, 0); #1;
        chk("fl_ready", 32'(in_ready), 32'd1);
        chk("fl_branch_held", 32'(Branch), 32'd1);
        step();
        drv(0, 32'h0, 0, 1); #1;
        chk("fl_dropped", 32'(out_valid), 32'd0);

        // illegal
        drv(1, 32'hFFFFFFFF, 0, 1); step();
        drv(0, 32'h0, 0, 1); #1;
        chk("ill_valid", 32'(out_valid), 32'd1);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_enables", 32'({RegWrite, MemWrite, Branch, Jump, Jump2, ALUsrc}), 32'd0);
        step();
`ifdef CTRL_DECODE_PERF_CNT_EN
        chk("cnt_issued", perf_issued, 32'd10);
        chk("cnt_bubbles", perf_bubbles, 32'd1);
        chk("cnt_flushes", perf_flushes, 32'd1);
`endif

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            drv($urandom_range(0, 3) != 0, gen(), $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) != 0);
            step();
        end

        // reset mid-transaction clears everything without a clock edge
        drv(1, SUB, 0, 0); step(); #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ctrl", 32'({RegWrite, MemWrite, Branch, Jump, Jump2, ALUsrc, illegal}), 32'd0);
        chk("mid_rst_fields", 32'({ResultSrc, ImmSrc, ALUctrl, funct3, rd}), 32'd0);
        drv(0, 32'h0, 0, 1);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
